// File: rtl/ro_ctrl_pkg.sv
// Shared constants and FSM state type for the ring-oscillator sweep controller.
package ro_ctrl_pkg;

  localparam int CNT_W_DFLT  = 24;
  localparam int GATE_W_DFLT = 20;
  localparam int SETTLE_DFLT = 16;
  localparam int NUM_RO_DFLT = 10;
  localparam int SEL_W       = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_GATE,
    ST_REPORT,
    ST_NEXT
  } ro_state_t;

endpackage

// File: rtl/ro_edge_sync.sv
// Two-flop synchronizer for the asynchronous oscillator mux output plus a
// single-cycle pulse on each synchronized rising edge.
module ro_edge_sync (
  input  logic clk,
  input  logic srst,
  input  logic async_in,
  output logic rise_pulse
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
      prev_reg <= 1'b0;
    end else begin
      meta_reg <= async_in;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign rise_pulse = sync_reg & ~prev_reg;

endmodule

// File: rtl/ro_sweep_controller.sv
// Walks the mux select over enabled ring oscillators and counts edges per gate window.
// Optional macro RO_STUCK_DETECT_EN: zero-count results are flagged and stuck_any is provided.
module ro_sweep_controller
  import ro_ctrl_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DFLT,
  parameter int GATE_W = GATE_W_DFLT,
  parameter int SETTLE = SETTLE_DFLT,
  parameter int NUM_RO = NUM_RO_DFLT
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              sweep_go,
  input  logic              abort,
  input  logic [NUM_RO-1:0] ro_mask,
  input  logic [4:0]        stage_cfg,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              osc_in,
  output logic [SEL_W-1:0]  sel_o,
  output logic [4:0]        s_o,
  output logic              start_o,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [SEL_W-1:0]  res_idx,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_flag,
  output logic              busy,
`ifdef RO_STUCK_DETECT_EN
  output logic              stuck_any,
`endif
  output logic              done
);

  localparam int               SET_W       = $clog2(SETTLE + 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  ro_state_t         state_reg;
  logic              go_prev_reg;
  logic [NUM_RO-1:0] mask_reg;
  logic [GATE_W-1:0] glen_reg;
  logic [SET_W-1:0]  settle_cnt_reg;
  logic [GATE_W-1:0] gate_cnt_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              sat_reg;

  logic              edge_pulse;
  logic              go_edge;
  logic              first_found;
  logic [SEL_W-1:0]  first_idx;
  logic              next_found;
  logic [SEL_W-1:0]  next_idx;
  logic [NUM_RO-1:0] above_mask;
  logic [CNT_W-1:0]  count_next;
  logic              sat_next;
  logic              stuck_now;

  ro_edge_sync u_edge_sync (
    .clk        (wb_clk_i),
    .srst       (wb_rst_i),
    .async_in   (osc_in),
    .rise_pulse (edge_pulse)
  );

  assign go_edge   = sweep_go & ~go_prev_reg;
  assign res_count = count_reg;

  // Returns {found, index of lowest set bit}.
  function automatic logic [SEL_W:0] lowest_set(input logic [NUM_RO-1:0] bits);
    logic [SEL_W:0] r;
    r = '0;
    for (int i = NUM_RO - 1; i >= 0; i--) begin
      if (bits[i]) r = {1'b1, SEL_W'(i)};
    end
    return r;
  endfunction

  for (genvar gi = 0; gi < NUM_RO; gi++) begin : g_above
    assign above_mask[gi] = mask_reg[gi] && (SEL_W'(gi) > sel_o);
  end

  assign {first_found, first_idx} = lowest_set(ro_mask);
  assign {next_found, next_idx}   = lowest_set(above_mask);

  always_comb begin
    count_next = count_reg;
    sat_next   = sat_reg;
    if (edge_pulse) begin
      if (count_reg == CNT_MAX) sat_next = 1'b1;
      else                      count_next = count_reg + CNT_W'(1);
    end
  end

`ifdef RO_STUCK_DETECT_EN
  assign stuck_now = (count_next == '0);
`else
  assign stuck_now = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg      <= ST_IDLE;
      go_prev_reg    <= 1'b0;
      mask_reg       <= '0;
      glen_reg       <= '0;
      settle_cnt_reg <= '0;
      gate_cnt_reg   <= '0;
      count_reg      <= '0;
      sat_reg        <= 1'b0;
      sel_o          <= '0;
      s_o            <= '0;
      start_o        <= 1'b0;
      res_valid      <= 1'b0;
      res_idx        <= '0;
      res_flag       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
`ifdef RO_STUCK_DETECT_EN
      stuck_any      <= 1'b0;
`endif
    end else begin
      go_prev_reg <= sweep_go;
      done        <= 1'b0;
      if (abort) begin
        // Abort wins over everything, including a simultaneous launch.
        state_reg <= ST_IDLE;
        start_o   <= 1'b0;
        res_valid <= 1'b0;
        busy      <= 1'b0;
        sel_o     <= '0;
        s_o       <= '0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (go_edge) begin
              if (first_found) begin
                mask_reg       <= ro_mask;
                glen_reg       <= (gate_len == '0) ? GATE_W'(1) : gate_len;
                sel_o          <= first_idx;
                s_o            <= stage_cfg;
                start_o        <= 1'b1;
                busy           <= 1'b1;
                settle_cnt_reg <= '0;
                state_reg      <= ST_SETTLE;
`ifdef RO_STUCK_DETECT_EN
                stuck_any      <= 1'b0;
`endif
              end else begin
                done <= 1'b1;
              end
            end
          end
          ST_SETTLE: begin
            if (settle_cnt_reg == SETTLE_LAST) begin
              count_reg    <= '0;
              sat_reg      <= 1'b0;
              gate_cnt_reg <= GATE_W'(1);
              state_reg    <= ST_GATE;
            end else begin
              settle_cnt_reg <= settle_cnt_reg + SET_W'(1);
            end
          end
          ST_GATE: begin
            count_reg <= count_next;
            sat_reg   <= sat_next;
            if (gate_cnt_reg == glen_reg) begin
              start_o   <= 1'b0;
              res_valid <= 1'b1;
              res_idx   <= sel_o;
              res_flag  <= sat_next | stuck_now;
              state_reg <= ST_REPORT;
`ifdef RO_STUCK_DETECT_EN
              stuck_any <= stuck_any | stuck_now;
`endif
            end else begin
              gate_cnt_reg <= gate_cnt_reg + GATE_W'(1);
            end
          end
          ST_REPORT: begin
            if (res_ready) begin
              res_valid <= 1'b0;
              state_reg <= ST_NEXT;
            end
          end
          ST_NEXT: begin
            if (next_found) begin
              sel_o          <= next_idx;
              start_o        <= 1'b1;
              settle_cnt_reg <= '0;
              state_reg      <= ST_SETTLE;
            end else begin
              sel_o     <= '0;
              s_o       <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state_reg <= ST_IDLE;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ro_sweep_controller.sv
// Scoreboard bench for ro_sweep_controller; a second CNT_W=4 instance shares stimulus for saturation.
module tb_ro_sweep_controller;

`ifdef RO_STUCK_DETECT_EN
  localparam bit STUCK_EN = 1'b1;
`else
  localparam bit STUCK_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        sweep_go;
  logic        abort;
  logic [9:0]  ro_mask;
  logic [4:0]  stage_cfg;
  logic [19:0] gate_len;
  logic        osc_in;
  logic        res_ready;

  logic [3:0]  sel_o, res_idx;
  logic [4:0]  s_o;
  logic        start_o, res_valid, res_flag, busy, done;
  logic [23:0] res_count;

  logic [3:0]  sel_s, res_idx_s, res_count_s;
  logic [4:0]  s_s;
  logic        start_s, res_valid_s, res_flag_s, busy_s, done_s;
`ifdef RO_STUCK_DETECT_EN
  logic        stuck_any, stuck_any_s;
`endif

  ro_sweep_controller dut (
    .wb_clk_i (clk), .wb_rst_i (rst), .sweep_go (sweep_go), .abort (abort),
    .ro_mask (ro_mask), .stage_cfg (stage_cfg), .gate_len (gate_len), .osc_in (osc_in),
    .sel_o (sel_o), .s_o (s_o), .start_o (start_o), .res_valid (res_valid),
    .res_ready (res_ready), .res_idx (res_idx), .res_count (res_count),
    .res_flag (res_flag), .busy (busy),
`ifdef RO_STUCK_DETECT_EN
    .stuck_any (stuck_any),
`endif
    .done (done)
  );

  ro_sweep_controller #(.CNT_W(4)) dut_small (
    .wb_clk_i (clk), .wb_rst_i (rst), .sweep_go (sweep_go), .abort (abort),
    .ro_mask (ro_mask), .stage_cfg (stage_cfg), .gate_len (gate_len), .osc_in (osc_in),
    .sel_o (sel_s), .s_o (s_s), .start_o (start_s), .res_valid (res_valid_s),
    .res_ready (res_ready), .res_idx (res_idx_s), .res_count (res_count_s),
    .res_flag (res_flag_s), .busy (busy_s),
`ifdef RO_STUCK_DETECT_EN
    .stuck_any (stuck_any_s),
`endif
    .done (done_s)
  );

  typedef struct packed {
    logic [3:0]  idx;
    logic [4:0]  cfg;
    logic [23:0] cnt;
    logic        flag;
    logic [3:0]  cnt_s;
    logic        flag_s;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   res_seen = 0;
  int   busy_cycles = 0;
  bit   osc_en = 1'b1;
  logic [3:0] last_sel = '0;
  logic [4:0] last_s = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Oscillator model: period of 4 clocks, edges offset from the clock edge.
  initial begin
    int ph;
    ph = 0;
    osc_in = 1'b0;
    forever begin
      @(posedge clk);
      ph = ph + 1;
      #2;
      osc_in = osc_en & ph[1];
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Scoreboard consumer: pops on every accepted result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (start_o) begin
        last_sel = sel_o;
        last_s   = s_o;
      end
      if (done) done_cnt++;
      if (busy) busy_cycles++;
      if (res_valid && res_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result got idx=%0d count=%0d expected none", res_idx, res_count);
        end else begin
          e = exp_q.pop_front();
          res_seen++;
          if ({res_idx, res_count, res_flag} !== {e.idx, e.cnt, e.flag}) begin
            errors++;
            $display("FAIL result got idx=%0d count=%0d flag=%0b expected idx=%0d count=%0d flag=%0b",
                     res_idx, res_count, res_flag, e.idx, e.cnt, e.flag);
          end
          checks++;
          if (last_sel !== e.idx) begin
            errors++;
            $display("FAIL sel_during_gate got %0d expected %0d", last_sel, e.idx);
          end
          checks++;
          if (last_s !== e.cfg) begin
            errors++;
            $display("FAIL stage_select got %0h expected %0h", last_s, e.cfg);
          end
          checks++;
          if ({res_valid_s, res_idx_s, res_count_s, res_flag_s} !== {1'b1, e.idx, e.cnt_s, e.flag_s}) begin
            errors++;
            $display("FAIL small_result got v=%0b idx=%0d count=%0d flag=%0b expected idx=%0d count=%0d flag=%0b",
                     res_valid_s, res_idx_s, res_count_s, res_flag_s, e.idx, e.cnt_s, e.flag_s);
          end
          $display("result idx=%0d count=%0d flag=%0b small_count=%0d small_flag=%0b",
                   res_idx, res_count, res_flag, res_count_s, res_flag_s);
        end
      end
    end
  end

  task automatic launch(input logic [9:0] mask, input logic [4:0] cfg, input int glen, input bit push);
    exp_t e;
    int   n;
    @(posedge clk);
    #1;
    ro_mask   = mask;
    stage_cfg = cfg;
    gate_len  = 20'(glen);
    sweep_go  = 1'b1;
    busy_cycles = 0;
    n = osc_en ? (((glen == 0) ? 1 : glen) / 4) : 0;
    if (push) begin
      for (int i = 0; i < 10; i++) begin
        if (mask[i]) begin
          e.idx    = 4'(i);
          e.cfg    = cfg;
          e.cnt    = 24'(n);
          e.flag   = STUCK_EN && (n == 0);
          e.cnt_s  = (n > 15) ? 4'hF : 4'(n);
          e.flag_s = (n > 15) || (STUCK_EN && (n == 0));
          exp_q.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
    sweep_go = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s_timeout busy=%0b after %0d cycles expected 0", name, busy, n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({sel_o, s_o, start_o, res_valid, res_idx, res_count, res_flag, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got sel=%0d s=%0h start=%0b valid=%0b idx=%0d count=%0d flag=%0b busy=%0b done=%0b expected all 0",
               sel_o, s_o, start_o, res_valid, res_idx, res_count, res_flag, busy, done);
    end
`ifdef RO_STUCK_DETECT_EN
    checks++;
    if (stuck_any !== 1'b0) begin
      errors++;
      $display("FAIL reset_stuck_any got %0b expected 0", stuck_any);
    end
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, start_o, done_cnt} !== {1'b0, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL post_reset_idle got busy=%0b start=%0b done_cnt=%0d expected 0 0 0", busy, start_o, done_cnt);
    end
    $display("test_reset complete");
  endtask

  task automatic test_single();
    int d0, r0;
    d0 = done_cnt;
    r0 = res_seen;
    launch(10'h001, 5'h15, 100, 1'b1);
    wait_idle(400, "single");
    checks++;
    if ({done_cnt, res_seen, busy_cycles} !== {d0 + 1, r0 + 1, 32'd118}) begin
      errors++;
      $display("FAIL single_sweep got done=%0d results=%0d busy_cycles=%0d expected %0d %0d 118",
               done_cnt, res_seen, busy_cycles, d0 + 1, r0 + 1);
    end
  endtask

  task automatic test_multi();
    int d0, r0;
    d0 = done_cnt;
    r0 = res_seen;
    launch(10'h205, 5'h0A, 40, 1'b1);
    wait_idle(1000, "multi");
    checks++;
    if ({done_cnt, res_seen, busy_cycles, exp_q.size()} !== {d0 + 1, r0 + 3, 32'd174, 32'd0}) begin
      errors++;
      $display("FAIL multi_sweep got done=%0d results=%0d busy_cycles=%0d pending=%0d expected %0d %0d 174 0",
               done_cnt, res_seen, busy_cycles, exp_q.size(), d0 + 1, r0 + 3);
    end
  endtask

  task automatic test_stall();
    int d0, r0, n;
    logic [3:0]  idx0, sel0;
    logic [23:0] cnt0;
    logic        flag0;
    d0 = done_cnt;
    r0 = res_seen;
    res_ready = 1'b0;
    launch(10'h001, 5'h1F, 20, 1'b1);
    n = 0;
    @(negedge clk);
    while (!res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!res_valid) begin
      errors++;
      $display("FAIL stall_wait_valid got valid=%0b expected 1", res_valid);
    end
    idx0  = res_idx;
    cnt0  = res_count;
    flag0 = res_flag;
    sel0  = sel_o;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if ({res_valid, res_idx, res_count, res_flag, start_o, busy, sel_o} !==
          {1'b1, idx0, cnt0, flag0, 1'b0, 1'b1, sel0}) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got valid=%0b idx=%0d count=%0d start=%0b busy=%0b expected 1 %0d %0d 0 1",
                 i, res_valid, res_idx, res_count, start_o, busy, idx0, cnt0);
      end
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    wait_idle(50, "stall");
    checks++;
    if ({done_cnt, res_seen} !== {d0 + 1, r0 + 1}) begin
      errors++;
      $display("FAIL stall_release got done=%0d results=%0d expected %0d %0d", done_cnt, res_seen, d0 + 1, r0 + 1);
    end
  endtask

  task automatic test_stuck();
    osc_en = 1'b0;
    repeat (8) @(negedge clk);
    launch(10'h003, 5'h03, 20, 1'b1);
    wait_idle(300, "stuck");
`ifdef RO_STUCK_DETECT_EN
    checks++;
    if ({stuck_any, stuck_any_s} !== 2'b11) begin
      errors++;
      $display("FAIL stuck_any_set got %0b%0b expected 11", stuck_any, stuck_any_s);
    end
`endif
    osc_en = 1'b1;
    launch(10'h001, 5'h03, 20, 1'b1);
    wait_idle(300, "unstuck");
`ifdef RO_STUCK_DETECT_EN
    checks++;
    if (stuck_any !== 1'b0) begin
      errors++;
      $display("FAIL stuck_any_clear got %0b expected 0", stuck_any);
    end
`endif
  endtask

  task automatic test_saturate();
    int r0;
    r0 = res_seen;
    launch(10'h001, 5'h11, 160, 1'b1);
    wait_idle(400, "saturate");
    checks++;
    if (res_seen !== r0 + 1) begin
      errors++;
      $display("FAIL saturate_results got %0d expected %0d", res_seen, r0 + 1);
    end
  endtask

  task automatic test_gate_zero();
    osc_en = 1'b0;
    repeat (8) @(negedge clk);
    launch(10'h001, 5'h02, 0, 1'b1);
    wait_idle(100, "gate_zero");
    checks++;
    if (busy_cycles !== 19) begin
      errors++;
      $display("FAIL gate_zero_latency got %0d expected 19", busy_cycles);
    end
    osc_en = 1'b1;
  endtask

  task automatic test_abort();
    int d0, r0;
    d0 = done_cnt;
    r0 = res_seen;
    launch(10'h205, 5'h07, 100, 1'b0);
    repeat (47) @(negedge clk);
    checks++;
    if ({busy, start_o} !== 2'b11) begin
      errors++;
      $display("FAIL abort_in_gate got busy=%0b start=%0b expected 1 1", busy, start_o);
    end
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, start_o, res_valid} !== 3'b000) begin
      errors++;
      $display("FAIL abort_drop got busy=%0b start=%0b valid=%0b expected 0 0 0", busy, start_o, res_valid);
    end
    @(posedge clk);
    #1;
    abort    = 1'b1;
    ro_mask  = 10'h205;
    sweep_go = 1'b1;
    @(posedge clk);
    #1;
    abort    = 1'b0;
    sweep_go = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if ({busy, done_cnt, res_seen} !== {1'b0, d0, r0}) begin
      errors++;
      $display("FAIL abort_quiet got busy=%0b done=%0d results=%0d expected 0 %0d %0d", busy, done_cnt, res_seen, d0, r0);
    end
    launch(10'h205, 5'h07, 40, 1'b1);
    wait_idle(1000, "abort_restart");
    checks++;
    if ({done_cnt, res_seen} !== {d0 + 1, r0 + 3}) begin
      errors++;
      $display("FAIL abort_restart got done=%0d results=%0d expected %0d %0d", done_cnt, res_seen, d0 + 1, r0 + 3);
    end
  endtask

  task automatic test_back_to_back();
    int d0, r0;
    d0 = done_cnt;
    r0 = res_seen;
    launch(10'h001, 5'h04, 20, 1'b1);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    ro_mask  = 10'h3FF;
    sweep_go = 1'b1;
    @(posedge clk);
    #1;
    sweep_go = 1'b0;
    wait_idle(300, "busy_go");
    checks++;
    if ({done_cnt, res_seen} !== {d0 + 1, r0 + 1}) begin
      errors++;
      $display("FAIL busy_go_ignored got done=%0d results=%0d expected %0d %0d", done_cnt, res_seen, d0 + 1, r0 + 1);
    end
    launch(10'h000, 5'h00, 20, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if ({done_cnt, busy_cycles, res_seen} !== {d0 + 2, 32'd0, r0 + 1}) begin
      errors++;
      $display("FAIL zero_mask got done=%0d busy_cycles=%0d results=%0d expected %0d 0 %0d",
               done_cnt, busy_cycles, res_seen, d0 + 2, r0 + 1);
    end
  endtask

  task automatic test_reset_mid();
    int d0, r0;
    d0 = done_cnt;
    r0 = res_seen;
    launch(10'h003, 5'h09, 20, 1'b0);
    repeat (25) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, start_o, res_valid, sel_o, s_o} !== '0) begin
      errors++;
      $display("FAIL reset_mid got busy=%0b start=%0b valid=%0b sel=%0d s=%0h expected all 0",
               busy, start_o, res_valid, sel_o, s_o);
    end
    repeat (40) @(negedge clk);
    checks++;
    if ({done_cnt, res_seen} !== {d0, r0}) begin
      errors++;
      $display("FAIL reset_mid_quiet got done=%0d results=%0d expected %0d %0d", done_cnt, res_seen, d0, r0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    sweep_go  = 1'b0;
    abort     = 1'b0;
    ro_mask   = '0;
    stage_cfg = '0;
    gate_len  = '0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    test_reset();
    test_single();
    test_multi();
    test_stall();
    test_stuck();
    test_saturate();
    test_gate_zero();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_results got %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
